// File: rtl/disparity_row_if.sv
// Pixel-intake and engine-control signals of the disparity row scheduler.
// Names carry the scheduler's point of view: i_ into it, o_ out of it.
interface disparity_row_if;
    logic       i_valid_l;
    logic       i_valid_r;
    logic       o_ready_l;
    logic       o_ready_r;
    logic       o_wr_en_l;
    logic       o_wr_en_r;
    logic [9:0] o_wr_addr_l;
    logic [9:0] o_wr_addr_r;
    logic       o_wr_bank;
    logic       o_eng_start;
    logic       o_eng_bank;
    logic [9:0] o_eng_row;
    logic       i_eng_done;
    logic       o_frame_done;
    logic       o_busy;

    modport slave (
        input  i_valid_l, i_valid_r, i_eng_done,
        output o_ready_l, o_ready_r, o_wr_en_l, o_wr_en_r, o_wr_addr_l, o_wr_addr_r,
               o_wr_bank, o_eng_start, o_eng_bank, o_eng_row, o_frame_done, o_busy
    );

    modport master (
        output i_valid_l, i_valid_r, i_eng_done,
        input  o_ready_l, o_ready_r, o_wr_en_l, o_wr_en_r, o_wr_addr_l, o_wr_addr_r,
               o_wr_bank, o_eng_start, o_eng_bank, o_eng_row, o_frame_done, o_busy
    );
endinterface

// File: rtl/disparity_row_scheduler.sv
// Ping-pong row buffering of a stereo pixel stream: fills one bank from both
// camera sides while the disparity engine consumes the other bank.
module disparity_row_scheduler #(
    parameter int LINE_W   = 800,
    parameter int NUM_ROWS = 600
) (
    input logic            clk,
    input logic            rst,
    disparity_row_if.slave bus
);
    localparam logic [9:0] LW       = 10'(LINE_W);
    localparam logic [9:0] LAST_ROW = 10'(NUM_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t     r_state, w_state_nxt;
    logic [9:0] r_cnt_l, r_cnt_r, r_eng_row;
    logic [1:0] r_full, w_full_nxt;
    logic       r_fill_bank, r_eng_bank, r_frame_done;
    logic       w_ready_l, w_ready_r, w_wr_en_l, w_wr_en_r;
    logic       w_row_filled, w_release, w_eng_pending, w_eng_start;

    assign w_ready_l    = (r_cnt_l < LW) && !r_full[r_fill_bank];
    assign w_ready_r    = (r_cnt_r < LW) && !r_full[r_fill_bank];
    assign w_wr_en_l    = bus.i_valid_l && w_ready_l;
    assign w_wr_en_r    = bus.i_valid_r && w_ready_r;
    assign w_row_filled = (r_cnt_l == LW) && (r_cnt_r == LW);
    assign w_release    = (r_state == S_WAIT) && bus.i_eng_done;
    // Looking at the flag being set this edge saves a cycle of start latency.
    assign w_eng_pending = r_full[r_eng_bank] || (w_row_filled && (r_fill_bank == r_eng_bank));

    always_comb begin
        w_full_nxt = r_full;
        if (w_release)    w_full_nxt[r_eng_bank]  = 1'b0;
        if (w_row_filled) w_full_nxt[r_fill_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_eng_pending) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (bus.i_eng_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_eng_start = (r_state == S_START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_l      <= '0;
            r_cnt_r      <= '0;
            r_full       <= '0;
            r_fill_bank  <= 1'b0;
            r_eng_bank   <= 1'b0;
            r_eng_row    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_full       <= w_full_nxt;
            r_frame_done <= w_release && (r_eng_row == LAST_ROW);
            if (w_row_filled) begin
                r_cnt_l     <= '0;
                r_cnt_r     <= '0;
                r_fill_bank <= ~r_fill_bank;
            end else begin
                if (w_wr_en_l) r_cnt_l <= r_cnt_l + 10'd1;
                if (w_wr_en_r) r_cnt_r <= r_cnt_r + 10'd1;
            end
            if (w_release) begin
                r_eng_bank <= ~r_eng_bank;
                r_eng_row  <= (r_eng_row == LAST_ROW) ? '0 : r_eng_row + 10'd1;
            end
        end
    end

    assign bus.o_ready_l    = w_ready_l;
    assign bus.o_ready_r    = w_ready_r;
    assign bus.o_wr_en_l    = w_wr_en_l;
    assign bus.o_wr_en_r    = w_wr_en_r;
    assign bus.o_wr_addr_l  = r_cnt_l;
    assign bus.o_wr_addr_r  = r_cnt_r;
    assign bus.o_wr_bank    = r_fill_bank;
    assign bus.o_eng_start  = w_eng_start;
    assign bus.o_eng_bank   = r_eng_bank;
    assign bus.o_eng_row    = r_eng_row;
    assign bus.o_frame_done = r_frame_done;
    assign bus.o_busy       = (r_state != S_IDLE) || (|r_full) || (|r_cnt_l) || (|r_cnt_r);
endmodule

// File: tb/tb_disparity_row_scheduler.sv
// Directed bench for disparity_row_scheduler (LINE_W=4, NUM_ROWS=2) with a
// row-occupancy reference model compared every cycle.
module tb_disparity_row_scheduler;
    localparam int LW = 4;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    disparity_row_if bus ();

    disparity_row_scheduler #(.LINE_W(LW), .NUM_ROWS(NR)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: rows filled / rows released by the engine, pixels per side.
    int m_cl = 0, m_cr = 0, m_filled = 0, m_rel = 0;
    bit m_started = 0, m_pulse = 0, m_fd = 0;
    int occ;
    bit acc_l, acc_r, was_idle;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cl = 0; m_cr = 0; m_filled = 0; m_rel = 0;
            m_started = 0; m_pulse = 0; m_fd = 0;
        end else begin
            occ      = m_filled - m_rel;
            acc_l    = bus.i_valid_l && (m_cl < LW) && (occ < 2);
            acc_r    = bus.i_valid_r && (m_cr < LW) && (occ < 2);
            was_idle = !m_started;
            m_fd     = 0;
            if (m_pulse) m_pulse = 0;
            else if (m_started && bus.i_eng_done) begin
                m_fd = ((m_rel % NR) == NR - 1);
                m_rel++;
                m_started = 0;
            end
            if (m_cl == LW && m_cr == LW) begin
                m_filled++;
                m_cl = 0;
                m_cr = 0;
            end else begin
                m_cl += int'(acc_l);
                m_cr += int'(acc_r);
            end
            if (was_idle && m_filled > m_rel) begin
                m_started = 1;
                m_pulse   = 1;
            end
        end
    end

    int  e_occ;
    bit  e_rdy_l, e_rdy_r;
    always @(negedge clk) begin
        e_occ   = m_filled - m_rel;
        e_rdy_l = (m_cl < LW) && (e_occ < 2);
        e_rdy_r = (m_cr < LW) && (e_occ < 2);
        chk("m_ready_l",    32'(bus.o_ready_l),    32'(e_rdy_l));
        chk("m_ready_r",    32'(bus.o_ready_r),    32'(e_rdy_r));
        chk("m_wr_en_l",    32'(bus.o_wr_en_l),    32'(bus.i_valid_l && e_rdy_l));
        chk("m_wr_en_r",    32'(bus.o_wr_en_r),    32'(bus.i_valid_r && e_rdy_r));
        chk("m_wr_addr_l",  32'(bus.o_wr_addr_l),  32'(m_cl));
        chk("m_wr_addr_r",  32'(bus.o_wr_addr_r),  32'(m_cr));
        chk("m_wr_bank",    32'(bus.o_wr_bank),    32'(m_filled % 2));
        chk("m_eng_start",  32'(bus.o_eng_start),  32'(m_pulse));
        chk("m_eng_bank",   32'(bus.o_eng_bank),   32'(m_rel % 2));
        chk("m_eng_row",    32'(bus.o_eng_row),    32'(m_rel % NR));
        chk("m_frame_done", 32'(bus.o_frame_done), 32'(m_fd));
        chk("m_busy",       32'(bus.o_busy),
            32'((m_cl != 0) || (m_cr != 0) || (e_occ > 0) || m_started));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vl, input logic vr, input logic dn);
        bus.i_valid_l  = vl;
        bus.i_valid_r  = vr;
        bus.i_eng_done = dn;
    endtask

    int na_l, na_r;

    initial begin
        drive(1, 0, 0);
        // Reset values, write strobe still follows valid
        @(negedge clk);
        chk("rst_ready_l", 32'(bus.o_ready_l), 1);
        chk("rst_ready_r", 32'(bus.o_ready_r), 1);
        chk("rst_wr_en_l", 32'(bus.o_wr_en_l), 1);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_eng_row", 32'(bus.o_eng_row), 0);
        chk("rst_eng_start", 32'(bus.o_eng_start), 0);
        tick();
        rst = 1'b0;

        // Row 0, both sides together
        drive(1, 1, 0);
        for (int i = 0; i < LW; i++) begin
            @(negedge clk);
            chk("a_addr_l", 32'(bus.o_wr_addr_l), 32'(i));
            chk("a_addr_r", 32'(bus.o_wr_addr_r), 32'(i));
            chk("a_bank", 32'(bus.o_wr_bank), 0);
            tick();
        end
        drive(0, 0, 0);
        @(negedge clk);
        chk("a_start_k1", 32'(bus.o_eng_start), 0);
        chk("a_ready_full_cnt", 32'(bus.o_ready_l), 0);
        tick();
        @(negedge clk);
        chk("a_start_k2", 32'(bus.o_eng_start), 1);
        chk("a_eng_bank", 32'(bus.o_eng_bank), 0);
        chk("a_eng_row", 32'(bus.o_eng_row), 0);
        tick();
        drive(0, 0, 1);
        @(negedge clk);
        chk("a_start_k3", 32'(bus.o_eng_start), 0);
        tick();
        drive(0, 0, 0);
        @(negedge clk);
        chk("a_row_next", 32'(bus.o_eng_row), 1);
        chk("a_busy_idle", 32'(bus.o_busy), 0);
        chk("a_no_frame", 32'(bus.o_frame_done), 0);
        tick();

        // Row 1: left first, right starts five cycles later
        drive(1, 0, 0);
        for (int i = 0; i < LW; i++) begin
            @(negedge clk);
            chk("b_addr_l", 32'(bus.o_wr_addr_l), 32'(i));
            chk("b_bank", 32'(bus.o_wr_bank), 1);
            tick();
        end
        drive(1, 0, 0);
        @(negedge clk);
        chk("b_ready_l_hold", 32'(bus.o_ready_l), 0);
        tick();
        drive(1, 1, 0);
        for (int i = 0; i < LW; i++) begin
            @(negedge clk);
            chk("b_ready_l_wait", 32'(bus.o_ready_l), 0);
            chk("b_no_start", 32'(bus.o_eng_start), 0);
            chk("b_addr_r", 32'(bus.o_wr_addr_r), 32'(i));
            tick();
        end
        drive(0, 0, 0);
        tick();
        @(negedge clk);
        chk("b_start", 32'(bus.o_eng_start), 1);
        chk("b_eng_bank", 32'(bus.o_eng_bank), 1);
        chk("b_eng_row", 32'(bus.o_eng_row), 1);
        tick();
        drive(0, 0, 1);
        tick();
        drive(0, 0, 0);
        @(negedge clk);
        chk("b_frame_done", 32'(bus.o_frame_done), 1);
        chk("b_row_wrap", 32'(bus.o_eng_row), 0);
        tick();
        @(negedge clk);
        chk("b_frame_once", 32'(bus.o_frame_done), 0);
        tick();

        // Engine stalled: both banks fill, then release
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 1, 0);
        na_l = 0; na_r = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            na_l += int'(bus.o_wr_en_l);
            na_r += int'(bus.o_wr_en_r);
            tick();
        end
        @(negedge clk);
        chk("c_acc_l_8", 32'(na_l), 8);
        chk("c_acc_r_8", 32'(na_r), 8);
        chk("c_ready_l_stall", 32'(bus.o_ready_l), 0);
        chk("c_ready_r_stall", 32'(bus.o_ready_r), 0);
        tick();
        drive(1, 1, 1);
        tick();
        drive(1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("c_ready_back", 32'(bus.o_ready_l), 1);
                chk("c_bank0_again", 32'(bus.o_wr_bank), 0);
            end
            na_l += int'(bus.o_wr_en_l);
            na_r += int'(bus.o_wr_en_r);
            tick();
        end
        chk("c_acc_l_12", 32'(na_l), 12);
        chk("c_acc_r_12", 32'(na_r), 12);
        drive(0, 0, 0);

        // Done while idle is ignored; reset in the middle of WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 1);
        tick();
        drive(0, 0, 0);
        @(negedge clk);
        chk("d_idle_busy", 32'(bus.o_busy), 0);
        chk("d_idle_row", 32'(bus.o_eng_row), 0);
        chk("d_idle_bank", 32'(bus.o_eng_bank), 0);
        tick();
        drive(1, 1, 0);
        repeat (LW) tick();
        drive(0, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("d_in_wait", 32'(bus.o_busy), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("d_rst_busy", 32'(bus.o_busy), 0);
        chk("d_rst_row", 32'(bus.o_eng_row), 0);
        tick();
        rst = 1'b0;
        drive(1, 1, 0);
        @(negedge clk);
        chk("d_after_bank", 32'(bus.o_wr_bank), 0);
        chk("d_after_addr", 32'(bus.o_wr_addr_l), 0);
        repeat (LW) tick();
        drive(0, 0, 0);
        tick();
        @(negedge clk);
        chk("d_after_start", 32'(bus.o_eng_start), 1);
        chk("d_after_row", 32'(bus.o_eng_row), 0);
        tick();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/disparity_row_scheduler.md
DISPARITY_ROW_SCHEDULER -- requirements
Module: disparity_row_scheduler

Interface
REQ-001 SHALL have parameter LINE_W, default 800: pixels per row per camera side.
REQ-002 SHALL have parameter NUM_ROWS, default 600: rows per frame.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 i_valid_l / i_valid_r  input  1  left/right pixel present this cycle.
REQ-007 o_ready_l / o_ready_r  output  1  scheduler accepts a pixel on that side.
REQ-008 o_wr_en_l / o_wr_en_r  output  1  write strobe to row buffer; equals i_valid_x AND o_ready_x.
REQ-009 o_wr_addr_l / o_wr_addr_r  output  10  pixel index within row.
REQ-010 o_wr_bank  output  1  row-buffer bank being filled (both sides share it).
REQ-011 o_eng_start  output  1  one-cycle start pulse to disparity engine.
REQ-012 o_eng_bank  output  1  bank the engine shall read; stable from start pulse until done.
REQ-013 o_eng_row  output  10  row index of the started row; stable from start pulse until done.
REQ-014 i_eng_done  input  1  engine finished current row.
REQ-015 o_frame_done  output  1  one-cycle pulse when row NUM_ROWS-1 completes.
REQ-016 o_busy  output  1  any row partially filled, buffered, or in engine.

Function
REQ-017 SHALL keep two banks (0/1) with flags full[1:0]; the fill bank and the engine bank SHALL alternate (ping-pong).
REQ-018 Side counters cnt_l, cnt_r SHALL count accepted pixels, 0..LINE_W.
REQ-019 o_ready_x SHALL be 1 iff cnt_x < LINE_W and full[fill_bank]==0; combinational from registers.
REQ-020 o_wr_addr_x SHALL equal cnt_x; cnt_x SHALL increment on each o_wr_en_x.
REQ-021 Sides SHALL be independent: a side at LINE_W SHALL hold o_ready low until the other side reaches LINE_W.
REQ-022 When cnt_l==LINE_W and cnt_r==LINE_W: next edge SHALL set full[fill_bank], clear both counters, toggle fill bank.
REQ-023 Engine FSM states IDLE, START, WAIT.
REQ-024 IDLE -> START when full[eng_bank]==1; START asserts o_eng_start for exactly one cycle, then -> WAIT.
REQ-025 WAIT -> IDLE on i_eng_done; same edge SHALL clear full[eng_bank], toggle eng_bank, increment eng_row.
REQ-026 eng_row SHALL wrap NUM_ROWS-1 -> 0; o_frame_done SHALL pulse in the cycle following that completion edge.
REQ-027 i_eng_done outside WAIT SHALL be ignored.
REQ-028 Latency: last pixel of row accepted in cycle k -> full set in k+1 -> o_eng_start high in cycle k+2 (engine idle).
REQ-029 Fill-completion on one bank and engine release of the other bank in the same cycle SHALL both take effect.
REQ-030 With both banks full, both o_ready SHALL be 0 until the engine releases a bank; no pixel lost or overwritten.
REQ-031 o_busy SHALL be 1 iff FSM!=IDLE, or any full flag set, or cnt_l/cnt_r nonzero.
REQ-032 Widths: counters and row index 10 bits; LINE_W and NUM_ROWS SHALL be <=1023.

Reset
REQ-033 rst SHALL asynchronously force: counters 0, full=00, fill bank 0, eng bank 0, eng_row 0, FSM IDLE.
REQ-034 During reset outputs SHALL be: o_ready 1/1 (until rst deasserts the reset value holds; write strobes still gated by i_valid), o_eng_start 0, o_frame_done 0, o_eng_bank 0, o_eng_row 0, o_busy 0, o_wr_bank 0.
REQ-035 Reset mid-row or mid-engine SHALL discard partial rows; next row after release SHALL be row 0 in bank 0.

Verification (LINE_W=4, NUM_ROWS=2)
REQ-036 Both sides valid 4 cycles from reset -> wr_addr 0,1,2,3 bank 0; o_eng_start 2 cycles after last pixel, eng_bank 0, eng_row 0.
REQ-037 Left 4 pixels then right delayed 5 cycles -> o_ready_l 0 after 4th left pixel until right completes; start only after right's 4th pixel.
REQ-038 Engine never done, 12 pixels per side offered -> banks 0 and 1 fill, both o_ready 0 after 8th pixel each side; i_eng_done -> ready returns, third row writes bank 0.
REQ-039 Two rows completed with i_eng_done -> o_frame_done one pulse after row 1 done; eng_row returns 0.
REQ-040 i_eng_done pulsed while IDLE -> no state change; rst asserted mid-WAIT -> o_busy 0 immediately, o_eng_row 0.
